hyperram_responder: RTL and testbench
=====================================

Name: hyperram_responder

Overview:
- Synthesizable HyperBus-style device (responder) that sits at the pad end of the HyperRAM controller's single-clock SDR bus. Used as the RAM model in simulation and in on-chip loopback builds.
- Decodes the 48-bit command/address (CA), counts access latency, then serves read/write bursts from an internal 16-bit word array.
- Also serves the ID0/ID1/CR0/CR1 register space.

Parameters:
- ADDR_W, 12, word-address width of the internal array (2^ADDR_W x 16-bit words).
- LATENCY, 6, initial access latency in ck_en cycles, counted after the third CA word.
- WRAP_LEN, 16, wrapped-burst group size in words (power of two).
- ID0_VAL, 16'h0C81, read-only ID0 value.
- ID1_VAL, 16'h0001, read-only ID1 value.
- REFRESH_DIV, 4, collision interval in transactions; used only with the optional feature.

Ports:
- clk  in  1  clock shared with the controller.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- csn  in  1  chip select, active-low.
- ck_en  in  1  bus clock enable (controller oe_clk); a bus beat occurs only on a cycle where csn=0 and ck_en=1.
- dq_in  in  16  controller-driven data/CA.
- dq_in_oe  in  1  controller is driving dq_in.
- rwds_in  in  1  write mask from controller (1 = mask word).
- dq_out  out  16  read data to controller.
- dq_oe  out  1  responder drives dq_out.
- rwds_out  out  1  read-data strobe / latency indicator.
- rwds_oe  out  1  responder drives rwds_out.

Behaviour:
Reset and general rules
- Reset values: dq_out=0, dq_oe=0, rwds_out=0, rwds_oe=0, state=IDLE, CR0=16'h8F1F, CR1=16'hFFC1. The array is not reset.
- All outputs are registered.
- csn=1 on any cycle in any state: next state IDLE, dq_oe=0, rwds_oe=0 on the following edge, and the burst is abandoned. Words already written remain written.
- Reset asserted mid-burst has the same effect, plus registers return to their reset values.
- Beats with ck_en=0 stall every state; counters and address hold.

CA decode
- States CA0, CA1, CA2 capture CA[47:32], CA[31:16], CA[15:0] on consecutive beats, starting from IDLE when csn falls.
- Fields: CA[47]=1 read / 0 write; CA[46]=1 register space; CA[45]=1 linear burst / 0 wrapped.
- Word address = {CA[44:16], CA[2:0]}, truncated to ADDR_W bits.
- rwds_oe=1 during CA0..CA2. rwds_out=0 (single latency), or per the optional feature.

Latency and data phases
- After CA2:
  - Register write: go to REGW, zero latency.
  - Anything else: go to LAT, which counts LATENCY beats (2*LATENCY if doubled), then moves to RDATA or WDATA.
- REGW: the first beat with dq_in_oe=1 writes the register selected by {CA[24],CA[0]}:
  - 2'b10 writes CR0, 2'b11 writes CR1.
  - 2'b00 and 2'b01 (ID registers) are ignored.
  - Then go to DONE.
- RDATA, on each beat:
  - dq_out <= mem[addr] (or the register for register space: 00=ID0, 01=ID1, 10=CR0, 11=CR1).
  - dq_oe=1, rwds_oe=1, rwds_out=1, and addr advances.
  - rwds_out=0 on stalled cycles.
  - Register reads return the same register on every beat.
- WDATA, on each beat with dq_in_oe=1: if rwds_in=0, mem[addr] <= dq_in. Addr advances whether or not the word is masked.
- DONE: outputs off; wait for csn=1.

Address advance
- Linear burst: addr+1, wrapping 2^ADDR_W-1 to 0.
- Wrapped burst: the low log2(WRAP_LEN) bits increment modulo WRAP_LEN and the upper bits hold.

Simultaneous events
- csn rising on the same edge as a write beat: the write commits and the state goes to IDLE.
- Fewer than 3 CA beats before csn rises: no access and no state change.

Optional Feature:
- HYPERRAM_RESP_REFRESH_EN, defined:
  - A transaction counter counts csn falling edges, modulo REFRESH_DIV.
  - When the counter equals 0 at CA0, rwds_out=1 through CA0..CA2 and LAT counts 2*LATENCY.
  - Register writes are unaffected.
- Not defined: rwds_out=0 during CA, latency is always LATENCY, no counter exists, and REFRESH_DIV is unused.

Test Plan:
- Write then read, linear: write CA 48'h2000_0000_0005 (write, memory space, linear; address 5) with data 16'hA5A5, 16'h1234. New transaction with read CA 48'hA000_0000_0005. Required: first rwds_out=1 beat exactly LATENCY beats after CA2; dq_out sequence A5A5, 1234.
- Masked write: write 3 words to address 8 with rwds_in=0,1,0 over old contents 0. Read back: word0 new, word1 = 0, word2 new.
- Register read: CA 48'hC000_0000_0001 -> dq_out = ID1_VAL with zero latency padding beyond LATENCY. CA 48'hC000_0100_0000 -> 16'h8F1F after reset.
- CR write: write CA 48'h6000_0100_0001 then data 16'hFFC2; readback of CR1 = 16'hFFC2. Write to the ID0 address leaves ID0 = ID0_VAL.
- Wrap: wrapped read (CA[45]=0) at address 14 for 4 beats with WRAP_LEN=16 -> addresses 14, 15, 0, 1. Linear read at 2^ADDR_W-1 -> next word from 0.
- Abort and stall: csn high after CA1 -> next cycle dq_oe=0, rwds_oe=0, memory unchanged. ck_en=0 for 3 cycles mid-read -> dq_out held, rwds_out=0, no addresses skipped. With HYPERRAM_RESP_REFRESH_EN, the 1st and 5th transactions after reset show rwds_out=1 during CA and 2*LATENCY latency.

Source files
------------

// File: rtl/hyperram_responder.sv
// hyperram_responder
// HyperBus-style responder for the single-clock SDR side of the HyperRAM
// controller. It is the RAM model in simulation and in on-chip loopback builds.
// It decodes the three-word command/address, counts the access latency, and
// then serves read/write bursts from an internal 16-bit word array. It also
// serves the ID0/ID1/CR0/CR1 register space.
//
// Optional feature macro: HYPERRAM_RESP_REFRESH_EN. When defined, every
// REFRESH_DIV-th transaction (starting with the first one after reset) reports
// a refresh collision. It does this by holding rwds_out high during CA and
// doubling the latency.
//
// Ports
//   clk       in   clock shared with the controller
//   rst       in   synchronous reset, active-low
//   csn       in   chip select, active-low
//   ck_en     in   bus clock enable; a beat is csn=0 && ck_en=1
//   dq_in     in   [15:0] controller-driven CA / write data
//   dq_in_oe  in   controller is driving dq_in
//   rwds_in   in   write mask (1 = keep old word)
//   dq_out    out  [15:0] read data (registered)
//   dq_oe     out  responder drives dq_out (registered)
//   rwds_out  out  read strobe / latency indicator (registered)
//   rwds_oe   out  responder drives rwds_out (registered)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | csn high; waiting for csn to fall
// CA0   | capture CA[47:32] (read/write, space, burst type, upper row)
// CA1   | capture CA[31:16] (row address, register select high bit)
// CA2   | capture CA[15:0]  (column, register select low bit)
// LAT   | latency down-counter; terminal count moves to the data phase
// REGW  | zero-latency register write, first driven beat
// RDATA | read burst, one word per beat
// WDATA | write burst, one word per driven beat
// DONE  | access finished; outputs off until csn rises

module hyperram_responder #(
  parameter int          ADDR_W      = 12,
  parameter int          LATENCY     = 6,
  parameter int          WRAP_LEN    = 16,
  parameter logic [15:0] ID0_VAL     = 16'h0C81,
  parameter logic [15:0] ID1_VAL     = 16'h0001,
  parameter int          REFRESH_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic        ck_en,
  input  logic [15:0] dq_in,
  input  logic        dq_in_oe,
  input  logic        rwds_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        rwds_out,
  output logic        rwds_oe
);

  localparam int CNT_W = $clog2(2 * LATENCY + 1);
  localparam logic [CNT_W-1:0]  LAT_SINGLE = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  LAT_DOUBLE = CNT_W'(2 * LATENCY - 1);
  localparam logic [ADDR_W-1:0] WRAP_MASK  = ADDR_W'(WRAP_LEN - 1);

  if (((WRAP_LEN & (WRAP_LEN - 1)) != 0) || (WRAP_LEN < 2) ||
      (REFRESH_DIV < 1) || (LATENCY < 1)) begin : g_param_err
    $error("hyperram_responder: illegal parameter value");
  end

  typedef enum logic [3:0] {
    ST_IDLE, ST_CA0, ST_CA1, ST_CA2, ST_LAT, ST_REGW, ST_RDATA, ST_WDATA, ST_DONE
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr, addr_d, addr_inc, addr_adv;
  logic              is_read, is_read_d;
  logic              is_reg, is_reg_d;
  logic              is_linear, is_linear_d;
  logic [1:0]        reg_sel, reg_sel_d;
  logic [15:0]       cr0, cr1;
  logic [15:0]       dq_out_d, rd_word;
  logic              dq_oe_d, rwds_out_d, rwds_oe_d;
  logic              mem_we, cr0_we, cr1_we;
  logic              beat;
  logic              dbl, dbl_start;

  logic [15:0] mem [0:(1 << ADDR_W) - 1];

  assign beat = !csn && ck_en;

  // dbl_start: collision decision for a transaction that is starting now.
  // dbl: decision latched for the transaction in progress.
`ifdef HYPERRAM_RESP_REFRESH_EN
  localparam int TC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  logic [TC_W-1:0] txn_cnt;
  logic            dbl_q;

  assign dbl_start = (txn_cnt == '0);
  assign dbl       = dbl_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      txn_cnt <= '0;
      dbl_q   <= 1'b0;
    end else if (state == ST_IDLE && !csn) begin
      dbl_q   <= dbl_start;
      txn_cnt <= (txn_cnt == TC_W'(REFRESH_DIV - 1)) ? '0 : txn_cnt + 1'b1;
    end
  end
`else
  assign dbl_start = 1'b0;
  assign dbl       = 1'b0;
`endif

  // A wrapped burst increments only the bits inside the wrap group.
  assign addr_inc = addr + 1'b1;
  assign addr_adv = is_linear ? addr_inc : ((addr & ~WRAP_MASK) | (addr_inc & WRAP_MASK));

  always_comb begin
    rd_word = mem[addr];
    if (is_reg) begin
      unique case (reg_sel)
        2'b00:   rd_word = ID0_VAL;
        2'b01:   rd_word = ID1_VAL;
        2'b10:   rd_word = cr0;
        default: rd_word = cr1;
      endcase
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    addr_d      = addr;
    is_read_d   = is_read;
    is_reg_d    = is_reg;
    is_linear_d = is_linear;
    reg_sel_d   = reg_sel;
    dq_out_d    = dq_out;
    dq_oe_d     = 1'b0;
    rwds_oe_d   = 1'b0;
    rwds_out_d  = 1'b0;
    mem_we      = 1'b0;
    cr0_we      = 1'b0;
    cr1_we      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!csn) begin
          state_d    = ST_CA0;
          rwds_oe_d  = 1'b1;
          rwds_out_d = dbl_start;
        end
      end
      ST_CA0: begin
        rwds_oe_d  = 1'b1;
        rwds_out_d = dbl;
        if (beat) begin
          is_read_d   = dq_in[15];
          is_reg_d    = dq_in[14];
          is_linear_d = dq_in[13];
          // CA[44:32] are word-address bits [31:19]
          addr_d      = ADDR_W'({dq_in[12:0], 19'd0});
          state_d     = ST_CA1;
        end
      end
      ST_CA1: begin
        rwds_oe_d  = 1'b1;
        rwds_out_d = dbl;
        if (beat) begin
          addr_d       = addr | ADDR_W'({dq_in, 3'd0});
          reg_sel_d[1] = dq_in[8];
          state_d      = ST_CA2;
        end
      end
      ST_CA2: begin
        rwds_oe_d  = 1'b1;
        rwds_out_d = dbl;
        if (beat) begin
          addr_d       = addr | ADDR_W'(dq_in[2:0]);
          reg_sel_d[0] = dq_in[0];
          rwds_oe_d    = 1'b0;
          rwds_out_d   = 1'b0;
          if (!is_read && is_reg) begin
            state_d = ST_REGW;
          end else begin
            state_d = ST_LAT;
            cnt_d   = dbl ? LAT_DOUBLE : LAT_SINGLE;
          end
        end
      end
      ST_LAT: begin
        if (beat) begin
          if (cnt == '0) state_d = is_read ? ST_RDATA : ST_WDATA;
          else           cnt_d   = cnt - 1'b1;
        end
      end
      ST_REGW: begin
        if (beat && dq_in_oe) begin
          cr0_we  = (reg_sel == 2'b10);
          cr1_we  = (reg_sel == 2'b11);
          state_d = ST_DONE;
        end
      end
      ST_RDATA: begin
        // drivers stay on through stalls once the first word is out
        dq_oe_d   = dq_oe;
        rwds_oe_d = dq_oe;
        if (beat) begin
          dq_out_d   = rd_word;
          dq_oe_d    = 1'b1;
          rwds_oe_d  = 1'b1;
          rwds_out_d = 1'b1;
          addr_d     = addr_adv;
        end
      end
      ST_WDATA: begin
        if (beat && dq_in_oe) begin
          mem_we = !rwds_in;
          addr_d = addr_adv;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (csn) begin
      state_d    = ST_IDLE;
      dq_oe_d    = 1'b0;
      rwds_oe_d  = 1'b0;
      rwds_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr      <= '0;
      is_read   <= 1'b0;
      is_reg    <= 1'b0;
      is_linear <= 1'b0;
      reg_sel   <= 2'b00;
      cr0       <= 16'h8F1F;
      cr1       <= 16'hFFC1;
      dq_out    <= 16'h0000;
      dq_oe     <= 1'b0;
      rwds_out  <= 1'b0;
      rwds_oe   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      addr      <= addr_d;
      is_read   <= is_read_d;
      is_reg    <= is_reg_d;
      is_linear <= is_linear_d;
      reg_sel   <= reg_sel_d;
      dq_out    <= dq_out_d;
      dq_oe     <= dq_oe_d;
      rwds_out  <= rwds_out_d;
      rwds_oe   <= rwds_oe_d;
      if (cr0_we) cr0 <= dq_in;
      if (cr1_we) cr1 <= dq_in;
    end
  end

  // The array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= dq_in;
  end

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder. Inputs are driven on the falling edge
// and outputs are sampled 1 time unit after the rising edge that consumed them.
module tb_hyperram_responder;

  localparam int LATENCY = 6;
`ifdef HYPERRAM_RESP_REFRESH_EN
  localparam int REFRESH_DIV = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csn = 1'b1;
  logic        ck_en = 1'b0;
  logic [15:0] dq_in = 16'h0;
  logic        dq_in_oe = 1'b0;
  logic        rwds_in = 1'b0;
  logic [15:0] dq_out;
  logic        dq_oe, rwds_out, rwds_oe;

  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  int   exp_lat = LATENCY;
  logic exp_dbl = 1'b0;

  always #5 clk = ~clk;

  hyperram_responder dut (
    .clk(clk), .rst(rst), .csn(csn), .ck_en(ck_en),
    .dq_in(dq_in), .dq_in_oe(dq_in_oe), .rwds_in(rwds_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .rwds_out(rwds_out), .rwds_oe(rwds_oe)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic c, input logic e, input logic [15:0] d,
                      input logic doe, input logic rw);
    @(negedge clk);
    csn = c; ck_en = e; dq_in = d; dq_in_oe = doe; rwds_in = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic next_txn();
    exp_dbl = 1'b0;
`ifdef HYPERRAM_RESP_REFRESH_EN
    exp_dbl = ((txn % REFRESH_DIV) == 0);
`endif
    exp_lat = exp_dbl ? 2 * LATENCY : LATENCY;
    txn++;
  endtask

  task automatic send_ca(input logic [47:0] ca);
    next_txn();
    tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("ca_rwds_oe", 16'(rwds_oe), 16'h1);
    check("ca_rwds_out", 16'(rwds_out), 16'(exp_dbl));
    tick(1'b0, 1'b1, ca[47:32], 1'b1, 1'b0);
    tick(1'b0, 1'b1, ca[31:16], 1'b1, 1'b0);
    check("ca1_rwds_out", 16'(rwds_out), 16'(exp_dbl));
    tick(1'b0, 1'b1, ca[15:0], 1'b1, 1'b0);
    check("ca_end_rwds_oe", 16'(rwds_oe), 16'h0);
  endtask

  task automatic end_tx();
    tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("end_oe", 16'({dq_oe, rwds_oe}), 16'h0);
  endtask

  task automatic lat_beats(input logic chk);
    for (int i = 0; i < exp_lat; i++) begin
      tick(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      if (chk) check("lat_quiet", 16'({dq_oe, rwds_out}), 16'h0);
    end
  endtask

  task automatic write_words(input logic [47:0] ca, input int n,
                             input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [2:0] mask);
    logic [15:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    send_ca(ca);
    lat_beats(1'b0);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, w[i], 1'b1, mask[i]);
    end_tx();
  endtask

  task automatic read_words(input string tag, input logic [47:0] ca, input int n,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    send_ca(ca);
    lat_beats(1'b1);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      check(tag, dq_out, e[i]);
      check("rd_strobe", 16'({dq_oe, rwds_oe, rwds_out}), 16'h7);
    end
    end_tx();
  endtask

  task automatic reg_write(input logic [47:0] ca, input logic [15:0] d);
    send_ca(ca);
    tick(1'b0, 1'b1, d, 1'b1, 1'b0);
    end_tx();
  endtask

  initial begin
    // reset
    repeat (3) tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("rst_dq_out", dq_out, 16'h0000);
    check("rst_oe", 16'({dq_oe, rwds_oe, rwds_out}), 16'h0);
    rst = 1'b1;
    tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    // register reads after reset
    read_words("cr0_reset", 48'hC000_0100_0000, 1, 16'h8F1F, 16'h0, 16'h0, 16'h0);
    read_words("id1", 48'hC000_0000_0001, 1, 16'h0001, 16'h0, 16'h0, 16'h0);

    // linear write then read
    write_words(48'h2000_0000_0005, 2, 16'hA5A5, 16'h1234, 16'h0, 3'b000);
    read_words("lin_rd", 48'hA000_0000_0005, 2, 16'hA5A5, 16'h1234, 16'h0, 16'h0);

    // masked write over zeros at 8..10
    write_words(48'h2000_0001_0000, 3, 16'h0000, 16'h0000, 16'h0000, 3'b000);
    write_words(48'h2000_0001_0000, 3, 16'h1111, 16'h2222, 16'h3333, 3'b010);

    // read back with a 3-cycle stall after the first word
    send_ca(48'hA000_0001_0000);
    lat_beats(1'b1);
    tick(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    check("mask_w0", dq_out, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      check("stall_hold", dq_out, 16'h1111);
      check("stall_strobe", 16'({dq_oe, rwds_oe, rwds_out}), 16'h6);
    end
    tick(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    check("mask_w1", dq_out, 16'h0000);
    tick(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    check("mask_w2", dq_out, 16'h3333);
    end_tx();

    // register writes
    reg_write(48'h6000_0100_0001, 16'hFFC2);
    read_words("cr1_wr", 48'hC000_0100_0001, 2, 16'hFFC2, 16'hFFC2, 16'h0, 16'h0);
    reg_write(48'h6000_0000_0000, 16'h1234);
    read_words("id0_ro", 48'hC000_0000_0000, 1, 16'h0C81, 16'h0, 16'h0, 16'h0);
    read_words("cr0_kept", 48'hC000_0100_0000, 1, 16'h8F1F, 16'h0, 16'h0, 16'h0);

    // wrap and end-of-array
    write_words(48'h2000_01FF_0007, 2, 16'hAAAA, 16'hB000, 16'h0, 3'b000);
    write_words(48'h2000_0000_0001, 1, 16'hB001, 16'h0, 16'h0, 3'b000);
    write_words(48'h2000_0001_0006, 2, 16'hBE0E, 16'hBE0F, 16'h0, 3'b000);
    read_words("wrap_rd", 48'h8000_0001_0006, 4, 16'hBE0E, 16'hBE0F, 16'hB000, 16'hB001);
    read_words("top_rd", 48'hA000_01FF_0007, 2, 16'hAAAA, 16'hB000, 16'h0, 16'h0);

    // abort after CA1
    next_txn();
    tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 16'h2000, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    check("abort_pre_rwds_oe", 16'(rwds_oe), 16'h1);
    tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("abort_oe", 16'({dq_oe, rwds_oe}), 16'h0);
    tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    read_words("abort_mem", 48'hA000_0000_0005, 2, 16'hA5A5, 16'h1234, 16'h0, 16'h0);

    // reset mid-burst
    send_ca(48'hA000_0000_0005);
    lat_beats(1'b0);
    tick(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    check("pre_rst_dq_oe", 16'(dq_oe), 16'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_dq_out", dq_out, 16'h0000);
    check("midrst_oe", 16'({dq_oe, rwds_oe, rwds_out}), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    csn = 1'b1;
    ck_en = 1'b0;
    txn = 0;
    tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    read_words("cr1_rst", 48'hC000_0100_0001, 1, 16'hFFC1, 16'h0, 16'h0, 16'h0);
    read_words("mem_kept", 48'hA000_0000_0005, 1, 16'hA5A5, 16'h0, 16'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
